timer_tick_multi: RTL and testbench

- Multi-channel, runtime-programmable tick generator: NUM_CH independent counters, each producing a one-cycle tick every PERIOD clocks (periodic mode) or once (one-shot mode).
- Replaces fixed-period flag generators: periods are writable at run time, channels start and stop individually, and one-shot completion is reported.
- Sits between the system clock/reset and LED/UART/debounce logic that needs timebases.

---
 rtl/timer_tick_multi_if.sv | 28 ++
 rtl/timer_tick_multi.sv | 140 ++++++++++++++
 tb/tb_timer_tick_multi.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/timer_tick_multi_if.sv
// Configuration/control bundle for timer_tick_multi: the master drives config
// writes and start/stop pulses; the timer block returns per-channel status.
interface timer_tick_multi_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 26
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic                 cfg_oneshot;
  logic [NUM_CH-1:0]    start;
  logic [NUM_CH-1:0]    stop;
  logic [NUM_CH-1:0]    tick;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH-1:0]    done;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
    input  tick, busy, done
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
    output tick, busy, done
  );
endinterface

// File: rtl/timer_tick_multi.sv
// Multi-channel programmable tick generator. Each channel holds a shadow
// config (written any time) and an active config (loaded on start and at
// every terminal count), so a mid-run write never truncates a period.

// One timer channel: IDLE/RUN FSM, up-counter, shadow/active config.
module timer_tick_ch #(
  parameter int CNT_WIDTH      = 26,
  parameter int DEFAULT_PERIOD = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic                 cfg_oneshot,
  input  logic                 start,
  input  logic                 stop,
  output logic                 tick,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] DEF_PER = CNT_WIDTH'(DEFAULT_PERIOD);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] sh_per, act_per, act_per_nxt, per_eff;
  logic                 sh_os, act_os, act_os_nxt;
  logic                 tick_nxt, done_nxt, term;

  // A programmed period of 0 is treated as 1.
  assign per_eff = (act_per == '0) ? CNT_WIDTH'(1) : act_per;
  assign term    = (state == RUN) && (cnt == per_eff - CNT_WIDTH'(1));
  assign busy    = (state == RUN);

  // State, counter, active config and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      act_per <= DEF_PER;
      act_os  <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      act_per <= act_per_nxt;
      act_os  <= act_os_nxt;
      tick    <= tick_nxt;
      done    <= done_nxt;
    end
  end

  // Shadow config captures every write addressed to this channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_per <= DEF_PER;
      sh_os  <= 1'b0;
    end else if (cfg_we) begin
      sh_per <= cfg_period;
      sh_os  <= cfg_oneshot;
    end
  end

  // Next state: stop beats start beats terminal count.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    act_per_nxt = act_per;
    act_os_nxt  = act_os;
    if (stop) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (start) begin
      state_nxt   = RUN;
      cnt_nxt     = '0;
      act_per_nxt = sh_per;
      act_os_nxt  = sh_os;
    end else if (term) begin
      cnt_nxt     = '0;
      act_per_nxt = sh_per;
      act_os_nxt  = sh_os;
      if (act_os) state_nxt = IDLE;
    end else if (state == RUN) begin
      cnt_nxt = cnt + CNT_WIDTH'(1);
    end
  end

  // Next outputs: tick on an uninterrupted terminal count, sticky done for one-shot.
  always_comb begin
    tick_nxt = term && !stop && !start;
    done_nxt = done;
    if (start && !stop)
      done_nxt = 1'b0;
    else if (tick_nxt && act_os)
      done_nxt = 1'b1;
  end
endmodule

// Top: array of channels, write decode by channel index.
module timer_tick_multi #(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 26,
  parameter int DEFAULT_PERIOD = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  timer_tick_multi_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] tick_v, busy_v, done_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices >= NUM_CH match no channel, so such writes are dropped.
    logic we_ch;
    assign we_ch = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    timer_tick_ch #(
      .CNT_WIDTH      (CNT_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_we      (we_ch),
      .cfg_period  (bus.cfg_period),
      .cfg_oneshot (bus.cfg_oneshot),
      .start       (bus.start[i]),
      .stop        (bus.stop[i]),
      .tick        (tick_v[i]),
      .busy        (busy_v[i]),
      .done        (done_v[i])
    );
  end

  assign bus.tick = tick_v;
  assign bus.busy = busy_v;
  assign bus.done = done_v;
endmodule

// File: tb/tb_timer_tick_multi.sv
// Bench for timer_tick_multi: directed scenarios then random traffic; a
// remaining-cycles reference model pushes expected outputs per edge and a
// negedge monitor compares them against the DUT.
module tb_timer_tick_multi;
  localparam int NC  = 3;   // 3 channels so cfg_ch = 3 is out of range
  localparam int CW  = 8;
  localparam int DEF = 20;
  localparam int CHW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_tick_multi_if #(.NUM_CH(NC), .CNT_WIDTH(CW)) bus ();

  timer_tick_multi #(
    .NUM_CH(NC), .CNT_WIDTH(CW), .DEFAULT_PERIOD(DEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [NC-1:0] tick;
    logic [NC-1:0] busy;
    logic [NC-1:0] done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: cycles remaining until the next tick per channel.
  int sh_per[NC], act_per[NC], rem[NC];
  bit sh_os[NC], act_os[NC], run[NC], dn[NC];

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      sh_per[c] = DEF; act_per[c] = DEF; rem[c] = 0;
      sh_os[c] = 0; act_os[c] = 0; run[c] = 0; dn[c] = 0;
    end
  endtask

  task automatic model_step(output exp_t e);
    e = '0;
    for (int c = 0; c < NC; c++) begin
      if (bus.stop[c]) begin
        run[c] = 0;
      end else if (bus.start[c]) begin
        run[c] = 1; act_per[c] = sh_per[c]; act_os[c] = sh_os[c];
        rem[c] = eff(act_per[c]); dn[c] = 0;
      end else if (run[c]) begin
        rem[c] = rem[c] - 1;
        if (rem[c] == 0) begin
          e.tick[c] = 1'b1;
          if (act_os[c]) begin
            run[c] = 0; dn[c] = 1;
          end else begin
            act_per[c] = sh_per[c]; act_os[c] = sh_os[c];
            rem[c] = eff(act_per[c]);
          end
        end
      end
      if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
        sh_per[c] = int'(bus.cfg_period);
        sh_os[c]  = bus.cfg_oneshot;
      end
      e.busy[c] = run[c];
      e.done[c] = dn[c];
    end
  endtask

  task automatic chk(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare against queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tick", bus.tick, e.tick);
      chk("busy", bus.busy, e.busy);
      chk("done", bus.done, e.done);
    end
  end

  // One clock of stimulus; called at posedge+2, returns at the next posedge+2.
  task automatic drive(input logic we, input int ch, input int per, input logic os,
                       input logic [NC-1:0] st, input logic [NC-1:0] sp);
    exp_t e;
    bus.cfg_we = we; bus.cfg_ch = CHW'(ch); bus.cfg_period = CW'(per);
    bus.cfg_oneshot = os; bus.start = st; bus.stop = sp;
    model_step(e);
    @(posedge clk);
    exp_q.push_back(e);
    #2;
    bus.cfg_we = 1'b0; bus.start = '0; bus.stop = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, '0, '0);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0;
    bus.cfg_oneshot = 1'b0; bus.start = '0; bus.stop = '0;
    model_reset();
    #2;
    chk("rst_tick", bus.tick, '0);
    chk("rst_busy", bus.busy, '0);
    chk("rst_done", bus.done, '0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(2);

    // ch0 periodic, period 5
    drive(1'b1, 0, 5, 1'b0, '0, '0);
    drive(1'b0, 0, 0, 1'b0, 3'b001, '0);
    idle(14);
    // ch1 one-shot, period 3, then restart clears done
    drive(1'b1, 1, 3, 1'b1, '0, '0);
    drive(1'b0, 0, 0, 1'b0, 3'b010, '0);
    idle(6);
    drive(1'b0, 0, 0, 1'b0, 3'b010, '0);
    idle(5);
    // ch0 mid-period write of 8
    idle(2);
    drive(1'b1, 0, 8, 1'b0, '0, '0);
    idle(22);
    // ch2 start+stop together, then stop at counter 2
    drive(1'b0, 0, 0, 1'b0, 3'b100, 3'b100);
    idle(2);
    drive(1'b0, 0, 0, 1'b0, 3'b100, '0);
    idle(2);
    drive(1'b0, 0, 0, 1'b0, '0, 3'b100);
    idle(3);
    // periods 0 and 1, periodic; out-of-range write
    drive(1'b1, 1, 0, 1'b0, '0, '0);
    drive(1'b1, 2, 1, 1'b0, '0, '0);
    drive(1'b0, 0, 0, 1'b0, 3'b110, '0);
    idle(6);
    drive(1'b1, 3, 2, 1'b1, '0, '0);
    idle(3);
    drive(1'b0, 0, 0, 1'b0, 3'b001, '0);
    idle(10);

    // async reset mid-cycle with channels running
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", bus.tick, '0);
    chk("arst_busy", bus.busy, '0);
    chk("arst_done", bus.done, '0);
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    idle(3);
    drive(1'b0, 0, 0, 1'b0, 3'b111, '0);
    idle(45);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [NC-1:0] st, sp;
      for (int c = 0; c < NC; c++) begin
        st[c] = ($urandom_range(0, 9) == 0);
        sp[c] = ($urandom_range(0, 15) == 0);
      end
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, 3),
            $urandom_range(0, 12), $urandom_range(0, 1) == 1, st, sp);
    end

    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
